// File: rtl/ddr_port_sched.sv
// ddr_port_sched: three-port (pc fetch / load / store) scheduler in front of a
// single-command DDR interface. Grants one requester at a time, issues a
// one-cycle command strobe, then waits for completion or a timeout.
// Optional feature: define DDR_SCHED_AGING_EN to let a starved pc fetch win
// after AGE_LIMIT lost arbitrations; undefined gives strict store > load > pc.
module ddr_port_sched #(
  parameter int unsigned AGE_LIMIT   = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_index_valid,
  input  logic [18:0] pc_index,
  output logic        pc_index_ready,
  output logic        pc_operation_done,
  input  logic        opload_index_valid,
  input  logic [18:0] opload_index,
  output logic        opload_index_ready,
  output logic        opload_operation_done,
  input  logic        opstore_index_valid,
  input  logic [18:0] opstore_index,
  input  logic [63:0] opstore_write_mask,
  input  logic [63:0] opstore_write_data,
  output logic        opstore_index_ready,
  output logic        opstore_operation_done,
  output logic        ddr_chip_enable,
  output logic [18:0] ddr_index,
  output logic        ddr_write_enable,
  output logic        ddr_burst_mode,
  output logic [63:0] ddr_opstore_write_mask,
  output logic [63:0] ddr_opstore_write_data,
  input  logic        ddr_operation_done,
  input  logic        ddr_ready,
  output logic        sched_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic [1:0] {K_PC, K_LOAD, K_STORE} kind_t;

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  // Reject parameter values that would produce zero-width counters.
  if (AGE_LIMIT < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("ddr_port_sched: AGE_LIMIT and TIMEOUT_CYC must be >= 1");
  end

  state_t        state, next_state;
  kind_t         kind_q, win_kind;
  logic [TW-1:0] tcnt;
  logic          any_valid;
  logic          grant;

`ifdef DDR_SCHED_AGING_EN
  localparam int unsigned AW = $clog2(AGE_LIMIT + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);
  logic [AW-1:0] pc_age;
  logic          pc_starved;

  // Aged pc flag: a pending fetch that has lost AGE_LIMIT grants.
  always_comb begin
    pc_starved = pc_index_valid && (pc_age == AGE_MAX);
  end

  // Saturating count of grants lost by a pending pc fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_age <= '0;
    end else if (!pc_index_valid) begin
      pc_age <= '0;
    end else if (grant) begin
      if (win_kind == K_PC)
        pc_age <= '0;
      else if (pc_age != AGE_MAX)
        pc_age <= pc_age + 1'b1;
    end
  end
`endif

  // Arbitration: fixed store > load > pc, optionally overridden by an aged pc.
  always_comb begin
    any_valid = pc_index_valid || opload_index_valid || opstore_index_valid;
    grant     = (state == S_IDLE) && ddr_ready && any_valid;
    if (opstore_index_valid)
      win_kind = K_STORE;
    else if (opload_index_valid)
      win_kind = K_LOAD;
    else
      win_kind = K_PC;
`ifdef DDR_SCHED_AGING_EN
    if (pc_starved)
      win_kind = K_PC;
`endif
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next state and per-state strobes; done and timeout are combinational in WAIT.
  always_comb begin
    next_state             = state;
    ddr_chip_enable        = 1'b0;
    pc_index_ready         = 1'b0;
    opload_index_ready     = 1'b0;
    opstore_index_ready    = 1'b0;
    pc_operation_done      = 1'b0;
    opload_operation_done  = 1'b0;
    opstore_operation_done = 1'b0;
    sched_timeout          = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant) next_state = S_ISSUE;
      end
      S_ISSUE: begin
        ddr_chip_enable     = 1'b1;
        pc_index_ready      = (kind_q == K_PC);
        opload_index_ready  = (kind_q == K_LOAD);
        opstore_index_ready = (kind_q == K_STORE);
        next_state          = S_WAIT;
      end
      S_WAIT: begin
        if (ddr_operation_done) begin
          pc_operation_done      = (kind_q == K_PC);
          opload_operation_done  = (kind_q == K_LOAD);
          opstore_operation_done = (kind_q == K_STORE);
          next_state             = S_IDLE;
        end else if (tcnt == T_LAST) begin
          sched_timeout = 1'b1;
          next_state    = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Command registers: captured on grant, held until the next grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      kind_q                 <= K_PC;
      ddr_index              <= '0;
      ddr_write_enable       <= 1'b0;
      ddr_burst_mode         <= 1'b0;
      ddr_opstore_write_mask <= '0;
      ddr_opstore_write_data <= '0;
    end else if (grant) begin
      kind_q           <= win_kind;
      ddr_write_enable <= (win_kind == K_STORE);
      ddr_burst_mode   <= (win_kind == K_PC);
      case (win_kind)
        K_STORE: begin
          ddr_index              <= opstore_index;
          ddr_opstore_write_mask <= opstore_write_mask;
          ddr_opstore_write_data <= opstore_write_data;
        end
        K_LOAD:  ddr_index <= opload_index;
        default: ddr_index <= pc_index;
      endcase
    end
  end

  // WAIT-cycle counter: zeroed while issuing so it starts at 0 on WAIT entry.
  always_ff @(posedge clock) begin
    if (reset)                tcnt <= '0;
    else if (state == S_ISSUE) tcnt <= '0;
    else if (state == S_WAIT)  tcnt <= tcnt + 1'b1;
  end

endmodule

// File: tb/tb_ddr_port_sched.sv
// Self-checking bench for ddr_port_sched: directed scenarios plus a randomized
// run checked against a timeline model of grants, strobes, done and timeouts.
module tb_ddr_port_sched;

  localparam int unsigned AGE = 4;
  localparam int unsigned TMO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        pc_index_valid, opload_index_valid, opstore_index_valid;
  logic [18:0] pc_index, opload_index, opstore_index;
  logic [63:0] opstore_write_mask, opstore_write_data;
  logic        pc_index_ready, pc_operation_done;
  logic        opload_index_ready, opload_operation_done;
  logic        opstore_index_ready, opstore_operation_done;
  logic        ddr_chip_enable, ddr_write_enable, ddr_burst_mode;
  logic [18:0] ddr_index;
  logic [63:0] ddr_opstore_write_mask, ddr_opstore_write_data;
  logic        ddr_operation_done, ddr_ready, sched_timeout;

  int errors = 0;
  int checks = 0;

  logic [7:0]   pulse_vec;
  logic [148:0] all_out;
  logic [148:0] held_out;
  assign pulse_vec = {ddr_chip_enable, pc_index_ready, opload_index_ready, opstore_index_ready,
                      pc_operation_done, opload_operation_done, opstore_operation_done, sched_timeout};
  assign held_out  = {ddr_index, ddr_write_enable, ddr_burst_mode,
                      ddr_opstore_write_mask, ddr_opstore_write_data};
  assign all_out   = {pulse_vec[7:0], held_out[148:8]} ;

  ddr_port_sched #(.AGE_LIMIT(AGE), .TIMEOUT_CYC(TMO)) dut (
    .clock(clock), .reset(reset),
    .pc_index_valid(pc_index_valid), .pc_index(pc_index),
    .pc_index_ready(pc_index_ready), .pc_operation_done(pc_operation_done),
    .opload_index_valid(opload_index_valid), .opload_index(opload_index),
    .opload_index_ready(opload_index_ready), .opload_operation_done(opload_operation_done),
    .opstore_index_valid(opstore_index_valid), .opstore_index(opstore_index),
    .opstore_write_mask(opstore_write_mask), .opstore_write_data(opstore_write_data),
    .opstore_index_ready(opstore_index_ready), .opstore_operation_done(opstore_operation_done),
    .ddr_chip_enable(ddr_chip_enable), .ddr_index(ddr_index),
    .ddr_write_enable(ddr_write_enable), .ddr_burst_mode(ddr_burst_mode),
    .ddr_opstore_write_mask(ddr_opstore_write_mask), .ddr_opstore_write_data(ddr_opstore_write_data),
    .ddr_operation_done(ddr_operation_done), .ddr_ready(ddr_ready),
    .sched_timeout(sched_timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    pc_index_valid = 1'b0; opload_index_valid = 1'b0; opstore_index_valid = 1'b0;
    pc_index = '0; opload_index = '0; opstore_index = '0;
    opstore_write_mask = '0; opstore_write_data = '0;
    ddr_operation_done = 1'b0; ddr_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    settle();
    checks++;
    if (pulse_vec !== 8'h00 || held_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h/%h exp=0/0", pulse_vec, held_out);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_pc_fetch();
    pc_index_valid = 1'b1; pc_index = 19'h00040; ddr_ready = 1'b1;
    tick();
    pc_index_valid = 1'b0;
    settle();
    checks++;
    if (pulse_vec !== 8'hC0) begin
      errors++; $display("FAIL pc_issue_pulses got=%h exp=c0", pulse_vec);
    end
    checks++;
    if ({ddr_index, ddr_burst_mode, ddr_write_enable} !== {19'h00040, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL pc_issue_cmd got=%h/%b/%b exp=00040/1/0", ddr_index, ddr_burst_mode, ddr_write_enable);
    end
    tick(); tick(); tick();
    ddr_operation_done = 1'b1;
    settle();
    checks++;
    if (pulse_vec !== 8'h08) begin
      errors++; $display("FAIL pc_done_pulse got=%h exp=08", pulse_vec);
    end
    tick();
    ddr_operation_done = 1'b0;
    settle();
    checks++;
    if (pulse_vec !== 8'h00) begin
      errors++; $display("FAIL pc_after_done got=%h exp=00", pulse_vec);
    end
  endtask

  task automatic test_store_over_load();
    opstore_index_valid = 1'b1; opstore_index = 19'h00100;
    opstore_write_mask = '1; opstore_write_data = 64'h00000000DEADBEEF;
    opload_index_valid = 1'b1; opload_index = 19'h12345;
    tick();
    opstore_index_valid = 1'b0;
    settle();
    checks++;
    if (pulse_vec !== 8'h90) begin
      errors++; $display("FAIL store_issue_pulses got=%h exp=90", pulse_vec);
    end
    checks++;
    if (held_out !== {19'h00100, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h00000000DEADBEEF}) begin
      errors++; $display("FAIL store_issue_cmd got=%h", held_out);
    end
    tick();
    ddr_operation_done = 1'b1;
    settle();
    checks++;
    if (pulse_vec !== 8'h02) begin
      errors++; $display("FAIL store_done_pulse got=%h exp=02", pulse_vec);
    end
    tick();
    ddr_operation_done = 1'b0;
    settle();
    checks++;
    if (pulse_vec !== 8'h00) begin
      errors++; $display("FAIL load_wait_idle got=%h exp=00", pulse_vec);
    end
    tick();
    opload_index_valid = 1'b0;
    settle();
    checks++;
    if (pulse_vec !== 8'hA0 || held_out !== {19'h12345, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h00000000DEADBEEF}) begin
      errors++; $display("FAIL load_issue got=%h/%h", pulse_vec, held_out);
    end
    tick();
    ddr_operation_done = 1'b1;
    settle();
    checks++;
    if (pulse_vec !== 8'h04) begin
      errors++; $display("FAIL load_done_pulse got=%h exp=04", pulse_vec);
    end
    tick();
    ddr_operation_done = 1'b0;
  endtask

  task automatic test_ready_low();
    pc_index_valid = 1'b1; opload_index_valid = 1'b1; opstore_index_valid = 1'b1;
    pc_index = 19'h00001; opload_index = 19'h00002; opstore_index = 19'h00003;
    ddr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      settle();
      checks++;
      if (pulse_vec !== 8'h00) begin
        errors++; $display("FAIL ready_low_no_grant cycle=%0d got=%h exp=00", i, pulse_vec);
      end
    end
    ddr_ready = 1'b1;
    tick();
    pc_index_valid = 1'b0; opload_index_valid = 1'b0; opstore_index_valid = 1'b0;
    settle();
    checks++;
    if (pulse_vec !== 8'h90 || ddr_index !== 19'h00003) begin
      errors++; $display("FAIL ready_high_grant got=%h/%h exp=90/00003", pulse_vec, ddr_index);
    end
    tick();
    ddr_operation_done = 1'b1;
    tick();
    ddr_operation_done = 1'b0;
  endtask

  task automatic test_timeout();
    opload_index_valid = 1'b1; opload_index = 19'h0ABCD;
    tick();
    opload_index_valid = 1'b0;
    settle();
    checks++;
    if (pulse_vec !== 8'hA0) begin
      errors++; $display("FAIL timeout_issue got=%h exp=a0", pulse_vec);
    end
    for (int k = 1; k <= TMO; k++) begin
      tick();
      settle();
      checks++;
      if (pulse_vec !== ((k == TMO) ? 8'h01 : 8'h00)) begin
        errors++; $display("FAIL timeout_wait k=%0d got=%h exp=%h", k, pulse_vec, (k == TMO) ? 8'h01 : 8'h00);
      end
    end
    tick();
    pc_index_valid = 1'b1; pc_index = 19'h00077;
    settle();
    checks++;
    if (pulse_vec !== 8'h00) begin
      errors++; $display("FAIL timeout_after got=%h exp=00", pulse_vec);
    end
    tick();
    pc_index_valid = 1'b0;
    settle();
    checks++;
    if (pulse_vec !== 8'hC0) begin
      errors++; $display("FAIL timeout_back_idle got=%h exp=c0", pulse_vec);
    end
    tick();
    ddr_operation_done = 1'b1;
    settle();
    checks++;
    if (pulse_vec !== 8'h08) begin
      errors++; $display("FAIL timeout_next_done got=%h exp=08", pulse_vec);
    end
    tick();
    ddr_operation_done = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    pc_index_valid = 1'b1; pc_index = 19'h55555;
    tick();
    pc_index_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    settle();
    checks++;
    if (pulse_vec !== 8'h00 || held_out !== '0) begin
      errors++; $display("FAIL reset_in_wait got=%h/%h exp=0/0", pulse_vec, held_out);
    end
    reset = 1'b0;
    ddr_operation_done = 1'b1;
    settle();
    checks++;
    if (pulse_vec !== 8'h00) begin
      errors++; $display("FAIL dropped_done_0 got=%h exp=00", pulse_vec);
    end
    tick();
    checks++;
    if (pulse_vec !== 8'h00) begin
      errors++; $display("FAIL dropped_done_1 got=%h exp=00", pulse_vec);
    end
    ddr_operation_done = 1'b0;
    tick();
  endtask

  task automatic test_aging();
    int  last;
    bit  found;
    bit  exp_pc;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pc_index_valid = 1'b1; pc_index = 19'h00111;
    opload_index_valid = 1'b1; opload_index = 19'($urandom);
`ifdef DDR_SCHED_AGING_EN
    last = AGE + 1;
`else
    last = 8;
`endif
    for (int arb = 1; arb <= last; arb++) begin
      found = 1'b0;
      for (int k = 0; k < 6 && !found; k++) begin
        tick();
        if (ddr_chip_enable === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
        errors++; $display("FAIL aging_strobe arb=%0d got=none exp=strobe", arb);
      end
`ifdef DDR_SCHED_AGING_EN
      exp_pc = (arb == AGE + 1);
`else
      exp_pc = 1'b0;
`endif
      checks++;
      if ({pc_index_ready, opload_index_ready} !== {exp_pc, !exp_pc}) begin
        errors++;
        $display("FAIL aging_winner arb=%0d got=%b%b exp=%b%b", arb, pc_index_ready, opload_index_ready, exp_pc, !exp_pc);
      end
      if (pc_index_ready === 1'b1) pc_index_valid = 1'b0;
      else opload_index = 19'($urandom);
      tick();
      ddr_operation_done = 1'b1;
      tick();
      ddr_operation_done = 1'b0;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    int          now, strobe_at, done_at, tmo_at, free_at, win, age, d;
    bit          drop_pc, drop_ld, drop_st, pc_aged;
    logic [7:0]  exp_p;
    logic [148:0] g_cmd, h_cmd;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    now = 0; strobe_at = -1; done_at = -1; tmo_at = -1; free_at = 0;
    win = 0; age = 0; h_cmd = '0; g_cmd = '0;
    drop_pc = 1'b0; drop_ld = 1'b0; drop_st = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      now++;
      if (drop_pc) pc_index_valid = 1'b0;
      if (drop_ld) opload_index_valid = 1'b0;
      if (drop_st) opstore_index_valid = 1'b0;
      drop_pc = 1'b0; drop_ld = 1'b0; drop_st = 1'b0;
      if (!pc_index_valid && $urandom_range(0, 3) == 0) begin
        pc_index_valid = 1'b1; pc_index = 19'($urandom);
      end
      if (!opload_index_valid && $urandom_range(0, 3) == 0) begin
        opload_index_valid = 1'b1; opload_index = 19'($urandom);
      end
      if (!opstore_index_valid && $urandom_range(0, 4) == 0) begin
        opstore_index_valid = 1'b1; opstore_index = 19'($urandom);
        opstore_write_mask = {$urandom, $urandom}; opstore_write_data = {$urandom, $urandom};
      end
      ddr_ready = ($urandom_range(0, 3) != 0);
      ddr_operation_done = (now == done_at) ||
                           ((now >= free_at || now == strobe_at) && $urandom_range(0, 7) == 0);
      settle();
      exp_p = 8'h00;
      if (now == strobe_at) begin
        exp_p[7] = 1'b1;
        exp_p[6 - win] = 1'b1;
        h_cmd = g_cmd;
      end
      if (now == done_at) exp_p[3 - win] = 1'b1;
      if (now == tmo_at)  exp_p[0] = 1'b1;
      checks++;
      if (pulse_vec !== exp_p) begin
        errors++; $display("FAIL rand_pulses t=%0d got=%h exp=%h", now, pulse_vec, exp_p);
      end
      checks++;
      if (held_out !== h_cmd) begin
        errors++; $display("FAIL rand_cmd t=%0d got=%h exp=%h", now, held_out, h_cmd);
      end
      if (now == strobe_at) begin
        if (win == 0) drop_pc = 1'b1;
        if (win == 1) drop_ld = 1'b1;
        if (win == 2) drop_st = 1'b1;
      end
      if (now >= free_at && ddr_ready &&
          (pc_index_valid || opload_index_valid || opstore_index_valid)) begin
        pc_aged = 1'b0;
`ifdef DDR_SCHED_AGING_EN
        pc_aged = pc_index_valid && (age == AGE);
`endif
        if (pc_aged)                  win = 0;
        else if (opstore_index_valid) win = 2;
        else if (opload_index_valid)  win = 1;
        else                          win = 0;
        case (win)
          2: g_cmd = {opstore_index, 1'b1, 1'b0, opstore_write_mask, opstore_write_data};
          1: g_cmd = {opload_index, 1'b0, 1'b0, h_cmd[127:0]};
          default: g_cmd = {pc_index, 1'b0, 1'b1, h_cmd[127:0]};
        endcase
        if (win == 0) age = 0;
        else if (pc_index_valid && age < AGE) age++;
        d = $urandom_range(1, TMO + 4);
        strobe_at = now + 1;
        if (d <= TMO) begin
          done_at = strobe_at + d; tmo_at = -1; free_at = done_at + 1;
        end else begin
          done_at = -1; tmo_at = strobe_at + TMO; free_at = tmo_at + 1;
        end
      end
      if (!pc_index_valid) age = 0;
    end
    idle_inputs();
    for (int i = 0; i < TMO + 4; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_pc_fetch();
    test_store_over_load();
    test_ready_low();
    test_timeout();
    test_reset_in_wait();
    test_aging();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
